fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline: owns the PC, drives instruction-memory address,
//  and registers the fetched word plus PC+4 into the IF/ID pipeline register.
//  IF_Inst feeds the instruction decoder directly. ID-stage redirects (branch/jump) and
//  hazard-unit stall/flush requests steer the next PC and bubble insertion.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INST   32'h0000_0000  word placed in IF/ID on bubble (sll $0,$0,0)
//  CNT_W      32             width of perf counters (FETCH_PERF_CNT_EN only)
// PORTS
//  Clk          in   1      clock, all state updates on rising edge
//  Rst_n        in   1      synchronous, active-low reset
//  Stall        in   1      hazard unit: hold PC and IF/ID
//  Flush        in   1      squash IF/ID contents, PC holds (refetch)
//  BranchTaken  in   1      ID resolved a taken branch
//  BranchTarget in   32     branch target address
//  Jump         in   1      ID holds a J/JAL
//  JumpIndex    in   26     26-bit jump index from decoder
//  ImemAddr     out  32     instruction memory address (= PC, combinational)
//  ImemData     in   32     instruction word, combinational read of ImemAddr
//  IF_Inst      out  32     IF/ID: instruction word to decoder
//  IF_PCplus4   out  32     IF/ID: PC+4 of IF_Inst
//  IF_Valid     out  1      IF/ID: 1 = real instruction, 0 = bubble
//  FetchCount   out  CNT_W  [FETCH_PERF_CNT_EN] valid instructions loaded
//  BubbleCount  out  CNT_W  [FETCH_PERF_CNT_EN] bubbles inserted
// BEHAVIOUR
//  Reset (Rst_n=0 at edge, overrides everything): PC=RESET_PC, IF_Inst=NOP_INST,
//   IF_PCplus4=0, IF_Valid=0, counters=0. Reset mid-operation behaves identically.
//  Jump target = {IF_PCplus4[31:28], JumpIndex, 2'b00}; branch target = {BranchTarget[31:2],2'b00}.
//  Priority per edge (first match wins):
//   1 Jump        : PC<=jump target; IF/ID<=bubble (NOP_INST, PC+4 of squashed word, Valid=0)
//   2 BranchTaken : PC<=branch target; IF/ID<=bubble. Jump&BranchTaken -> jump wins.
//   3 Flush       : PC holds; IF/ID<=bubble
//   4 Stall       : PC and IF/ID hold all bits
//   5 else        : PC<=PC+4; IF_Inst<=ImemData; IF_PCplus4<=PC+4; IF_Valid<=1
//  Redirect overrides Stall (wrong-path word must not survive). Stall with Flush -> flush.
//  Latency: word at ImemAddr in cycle N appears on IF_Inst in cycle N+1.
//  PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0); no trap.
//  ImemAddr is never registered separately; it is PC.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: FetchCount +1 on every case-5 edge; BubbleCount +1 on every
//   case 1/2/3 edge; both saturate at all-ones; stall edges count neither.
//  Undefined: counters, their logic and both ports absent.
// STRUCTURE
//  Shared package mips_pipe_pkg: INST_W=32, ADDR_W=32, NOP_INST, RESET_PC default,
//   JUMP_IDX_W=26; next-PC select encoding as a localparam enum.
//  Sub-module if_id_reg: IF/ID register with load/clear/hold controls and Valid bit;
//   fetch_stage keeps PC, next-PC mux, priority logic and counters.
// TESTING
//  Reset then release, Imem returns addr-tagged words -> ImemAddr 0,4,8..; IF_Inst lags 1 cycle, IF_Valid 1 from 2nd edge.
//  Stall=1 for 3 cycles at PC=0x10 -> PC, IF_Inst, IF_PCplus4 frozen; resumes at 0x14.
//  Jump, JumpIndex=26'h0000040, IF_PCplus4=0x1000_0008 -> PC=0x1000_0100, one bubble, Valid=0.
//  Jump and BranchTaken (target 0x200) together with Stall -> PC=jump target, bubble inserted.
//  Flush at PC=0x20 -> IF_Valid=0, IF_Inst=NOP_INST, next fetch address still 0x20.
//  PC=0xFFFF_FFFC free-run -> next PC 0x0; Rst_n=0 mid-stall -> all reset values next edge.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared constants and next-PC select encoding for the MIPS pipeline front end.
package mips_pipe_pkg;

  localparam int INST_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int JUMP_IDX_W = 26;

  localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_HOLD   = 2'd1,
    NPC_BRANCH = 2'd2,
    NPC_JUMP   = 2'd3
  } npc_sel_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched word, clear to a bubble, or hold.
module if_id_reg
  import mips_pipe_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [INST_W-1:0] inst_in,
  input  logic [ADDR_W-1:0] pcplus4_in,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pcplus4_out,
  output logic              valid_out
);

  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] pcplus4_q, pcplus4_d;
  logic              valid_q, valid_d;

  // A bubble keeps the PC+4 of the squashed word so a later jump still sees a sane region.
  always_comb begin
    inst_d    = inst_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (clear) begin
      inst_d    = NOP_INST;
      pcplus4_d = pcplus4_in;
      valid_d   = 1'b0;
    end else if (load) begin
      inst_d    = inst_in;
      pcplus4_d = pcplus4_in;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      inst_q    <= NOP_INST;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      inst_q    <= inst_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign inst_out    = inst_q;
  assign pcplus4_out = pcplus4_q;
  assign valid_out   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, next-PC priority mux and IF/ID register.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import mips_pipe_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
`ifdef FETCH_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  BranchTaken,
  input  logic [ADDR_W-1:0]     BranchTarget,
  input  logic                  Jump,
  input  logic [JUMP_IDX_W-1:0] JumpIndex,
  output logic [ADDR_W-1:0]     ImemAddr,
  input  logic [INST_W-1:0]     ImemData,
  output logic [INST_W-1:0]     IF_Inst,
  output logic [ADDR_W-1:0]     IF_PCplus4,
  output logic                  IF_Valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      FetchCount,
  output logic [CNT_W-1:0]      BubbleCount
`endif
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4, jump_target, branch_target;
  npc_sel_e          npc_sel;
  logic              ifid_load, ifid_clear;
  logic [1:0]        unused_bt_bits;

  assign pc_plus4      = pc_q + 32'd4;
  assign jump_target   = {IF_PCplus4[31:28], JumpIndex, 2'b00};
  assign branch_target = {BranchTarget[31:2], 2'b00};
  assign unused_bt_bits = BranchTarget[1:0];

  // Redirects outrank Flush and Stall so a wrong-path word never survives in IF/ID.
  always_comb begin
    npc_sel    = NPC_SEQ;
    ifid_load  = 1'b0;
    ifid_clear = 1'b0;
    if (Jump) begin
      npc_sel    = NPC_JUMP;
      ifid_clear = 1'b1;
    end else if (BranchTaken) begin
      npc_sel    = NPC_BRANCH;
      ifid_clear = 1'b1;
    end else if (Flush) begin
      npc_sel    = NPC_HOLD;
      ifid_clear = 1'b1;
    end else if (Stall) begin
      npc_sel    = NPC_HOLD;
    end else begin
      ifid_load  = 1'b1;
    end
  end

  always_comb begin
    pc_d = pc_plus4;
    case (npc_sel)
      NPC_SEQ:    pc_d = pc_plus4;
      NPC_HOLD:   pc_d = pc_q;
      NPC_BRANCH: pc_d = branch_target;
      NPC_JUMP:   pc_d = jump_target;
      default:    pc_d = pc_plus4;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign ImemAddr = pc_q;

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .load        (ifid_load),
    .clear       (ifid_clear),
    .inst_in     (ImemData),
    .pcplus4_in  (pc_plus4),
    .inst_out    (IF_Inst),
    .pcplus4_out (IF_PCplus4),
    .valid_out   (IF_Valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (ifid_load && (fetch_cnt_q != '1))   fetch_cnt_d  = fetch_cnt_q + CNT_W'(1);
    if (ifid_clear && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign FetchCount  = fetch_cnt_q;
  assign BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized control traffic
// against a behavioural model of the IF stage.
module tb_fetch_stage;

  logic        Clk = 1'b0;
  logic        Rst_n, Stall, Flush, BranchTaken, Jump;
  logic [31:0] BranchTarget;
  logic [25:0] JumpIndex;
  logic [31:0] ImemAddr, ImemData, IF_Inst, IF_PCplus4;
  logic        IF_Valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount, BubbleCount;
`endif

  always #5 Clk = ~Clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return 32'hC0DE_0000 ^ (a * 32'd3);
  endfunction

  assign ImemData = tag(ImemAddr);

  fetch_stage dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Stall        (Stall),
    .Flush        (Flush),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpIndex    (JumpIndex),
    .ImemAddr     (ImemAddr),
    .ImemData     (ImemData),
    .IF_Inst      (IF_Inst),
    .IF_PCplus4   (IF_PCplus4),
    .IF_Valid     (IF_Valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCount   (FetchCount),
    .BubbleCount  (BubbleCount)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the IF stage must hold after each edge.
  logic [31:0] m_pc, m_inst, m_pc4;
  logic        m_valid;
  logic [31:0] m_fetch, m_bubble;
  bit          m_live = 0;

  always @(posedge Clk) begin
    bit bubble;
    logic [31:0] new_pc;
    bubble = 0;
    if (!Rst_n) begin
      m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 0;
      m_fetch = 0; m_bubble = 0; m_live = 1;
    end else if (m_live) begin
      new_pc = m_pc;
      if (Jump) begin
        new_pc = {m_pc4[31:28], JumpIndex, 2'b00}; bubble = 1;
      end else if (BranchTaken) begin
        new_pc = BranchTarget & 32'hFFFF_FFFC; bubble = 1;
      end else if (Flush) begin
        bubble = 1;
      end else if (!Stall) begin
        m_inst = tag(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1;
        new_pc = m_pc + 32'd4;
        if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
      end
      if (bubble) begin
        m_inst = 32'h0; m_pc4 = m_pc + 32'd4; m_valid = 0;
        if (m_bubble != 32'hFFFF_FFFF) m_bubble++;
      end
      m_pc = new_pc;
    end
  end

  always @(negedge Clk) begin
    if (m_live) begin
      cmp("imem_addr", ImemAddr, m_pc);
      cmp("if_inst", IF_Inst, m_inst);
      cmp("if_pcplus4", IF_PCplus4, m_pc4);
      cmp("if_valid", {31'd0, IF_Valid}, {31'd0, m_valid});
`ifdef FETCH_PERF_CNT_EN
      cmp("fetch_count", FetchCount, m_fetch);
      cmp("bubble_count", BubbleCount, m_bubble);
`endif
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Stall = 0; Flush = 0; BranchTaken = 0; Jump = 0;
  endtask

  initial begin
    Rst_n = 0; idle(); BranchTarget = 0; JumpIndex = 0;
    step();
    cmp("rst_pc", ImemAddr, 32'h0);
    cmp("rst_inst", IF_Inst, 32'h0);
    cmp("rst_pc4", IF_PCplus4, 32'h0);
    cmp("rst_valid", {31'd0, IF_Valid}, 32'd0);

    Rst_n = 1;
    step();
    cmp("run_pc", ImemAddr, 32'h4);
    cmp("run_inst", IF_Inst, tag(32'h0));
    cmp("run_valid", {31'd0, IF_Valid}, 32'd1);
    repeat (3) step();
    cmp("pre_stall_pc", ImemAddr, 32'h10);

    Stall = 1;
    repeat (3) step();
    cmp("stall_pc", ImemAddr, 32'h10);
    cmp("stall_pc4", IF_PCplus4, 32'h10);
    cmp("stall_inst", IF_Inst, tag(32'hC));
    Stall = 0;
    step();
    cmp("resume_pc", ImemAddr, 32'h14);
    repeat (3) step();

    Flush = 1;
    step();
    Flush = 0;
    cmp("flush_pc", ImemAddr, 32'h20);
    cmp("flush_inst", IF_Inst, 32'h0);
    cmp("flush_valid", {31'd0, IF_Valid}, 32'd0);

    BranchTaken = 1; BranchTarget = 32'h1000_0004;
    step();
    BranchTaken = 0;
    step();
    cmp("pre_jump_pc4", IF_PCplus4, 32'h1000_0008);
    Jump = 1; JumpIndex = 26'h0000040;
    step();
    Jump = 0;
    cmp("jump_pc", ImemAddr, 32'h1000_0100);
    cmp("jump_valid", {31'd0, IF_Valid}, 32'd0);

    Jump = 1; JumpIndex = 26'h0000080; BranchTaken = 1; BranchTarget = 32'h200; Stall = 1;
    step();
    idle();
    cmp("jbs_pc", ImemAddr, 32'h1000_0200);
    cmp("jbs_valid", {31'd0, IF_Valid}, 32'd0);

    BranchTaken = 1; BranchTarget = 32'hFFFF_FFFF;
    step();
    BranchTaken = 0;
    cmp("br_mask_pc", ImemAddr, 32'hFFFF_FFFC);
    step();
    cmp("wrap_pc", ImemAddr, 32'h0);
    cmp("wrap_pc4", IF_PCplus4, 32'h0);

    Stall = 1;
    step();
    Rst_n = 0;
    step();
    cmp("midrst_pc", ImemAddr, 32'h0);
    cmp("midrst_inst", IF_Inst, 32'h0);
    cmp("midrst_valid", {31'd0, IF_Valid}, 32'd0);
    Rst_n = 1; Stall = 0;

    for (int i = 0; i < 3000; i++) begin
      Jump         = ($urandom_range(0, 99) < 5);
      BranchTaken  = ($urandom_range(0, 99) < 8);
      Flush        = ($urandom_range(0, 99) < 6);
      Stall        = ($urandom_range(0, 99) < 20);
      Rst_n        = ($urandom_range(0, 199) != 0);
      BranchTarget = $urandom;
      JumpIndex    = 26'($urandom);
      step();
    end
    Rst_n = 1; idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
